dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH_P, default 32, meaning the data word width.
REQ-002 The block SHALL have parameter DATA_ADDR_WIDTH_P, default 32, meaning the requester byte-address width.
REQ-003 The block SHALL have parameter MEM_ADDR_WIDTH_P, default 8, meaning the word-index width (256 words).
REQ-004 clk  in  1  the single clock; all logic SHALL be clocked on its rising edge.
REQ-005 reset  in  1  synchronous, active-low; the block is in reset when reset=0 at a rising clk edge.
REQ-006 i_core_req, i_core_we  in  1 each  core request and write flag.
REQ-007 i_core_addr  in  DATA_ADDR_WIDTH_P  core byte address; i_core_wdata  in  DATA_WIDTH_P  core write data.
REQ-008 o_core_gnt, o_core_rvalid  out  1 each  core request accepted; core read data valid.
REQ-009 o_core_rdata  out  DATA_WIDTH_P  core read data; o_core_stall  out  1  core must hold its PC and instruction.
REQ-010 i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata, o_dbg_gnt, o_dbg_rvalid, o_dbg_rdata: debug/loader port, same widths and meanings as the core port.
REQ-011 o_mem_en, o_mem_we  out  1 each  memory access strobe and write enable.
REQ-012 o_mem_addr  out  MEM_ADDR_WIDTH_P  word index; o_mem_wdata  out  DATA_WIDTH_P  write data.
REQ-013 i_mem_rdata  in  DATA_WIDTH_P  memory read data, valid one cycle after an o_mem_en read.
REQ-014 o_err  out  1  one-cycle pulse on an out-of-range access.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-016 IDLE: when any request is pending, the block SHALL latch the winner's we, addr and wdata and move to ACCESS; with no request pending it SHALL stay in IDLE.
REQ-017 ACCESS: the block SHALL assert o_mem_en for one cycle with the latched fields and pulse the winner's gnt; a write SHALL return to IDLE and a read SHALL go to RESP.
REQ-018 RESP: the block SHALL register i_mem_rdata onto the winner's rdata, pulse its rvalid for one cycle and return to IDLE.
REQ-019 Latency SHALL be: write gnt 1 cycle after the request is sampled in IDLE; read rvalid 2 cycles after it; throughput is 2 cycles per write and 3 cycles per read.
REQ-020 The word index SHALL be o_mem_addr = addr[MEM_ADDR_WIDTH_P+1:2]; bits [1:0] SHALL be ignored.
REQ-021 Out of range (any addr bit above MEM_ADDR_WIDTH_P+1 set): the FSM sequence and gnt/rvalid timing are unchanged, o_mem_en SHALL stay 0, rdata SHALL be 0, and o_err SHALL pulse in ACCESS.
REQ-022 o_core_stall SHALL be i_core_req AND NOT (o_core_gnt on a write OR o_core_rvalid on a read), combinationally.
REQ-023 Requesters SHALL hold req and all fields until gnt (write) or rvalid (read); a latched transaction SHALL always complete, and abort is not supported.
REQ-024 A requester that drops req while the block is in IDLE SHALL NOT be latched.
REQ-025 gnt and rvalid SHALL never be asserted for both ports in the same cycle.

Reset
REQ-026 In reset, the FSM SHALL go to IDLE, the round-robin pointer SHALL favour the core, and all gnt, rvalid, rdata, o_err and o_mem_* outputs SHALL be 0.
REQ-027 o_mem_en SHALL be gated by reset=1, so no memory write is issued in a reset cycle, including reset asserted mid-ACCESS.
REQ-028 A read interrupted by reset SHALL produce no rvalid.

Configuration
REQ-029 With DMEM_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the port not granted most recently.
REQ-030 Without DMEM_ARB_ROUND_ROBIN_EN, the core SHALL always win and the pointer register SHALL be absent.

Structure
REQ-031 A shared package dmem_arb_pkg SHALL hold the state enum (IDLE/ACCESS/RESP) and the port-index constants CORE_PORT=0 and DBG_PORT=1.
REQ-032 A sub-module dmem_arb_pick (two-request priority/round-robin picker) SHALL be used; all other logic SHALL stay inline.

Verification
REQ-033 Core write of 7 to address 80 -> o_mem_addr=20, o_mem_we=1 and o_core_gnt in the next cycle; stall high for exactly 1 cycle.
REQ-034 Core read of address 80 after REQ-033 -> o_core_rvalid 2 cycles later with rdata=7; stall high for 2 cycles.
REQ-035 Core and dbg reads issued in the same cycle, RR defined -> core serviced first and dbg second; RR undefined with the core requesting continuously -> dbg never granted.
REQ-036 Dbg read of address 0x400 -> o_err pulse, o_mem_en=0, and o_dbg_rvalid with rdata=0 at the normal timing.
REQ-037 reset=0 in the ACCESS cycle of a core write of 5 to address 84 -> word 21 unchanged, no gnt, FSM in IDLE.
REQ-038 Dbg loader writes words 0..3, then the core runs the sw/lw/sw sequence -> word 21 (address 84) holds 7.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state encoding
// and requester port indices.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic CORE_PORT = 1'b0;
    localparam logic DBG_PORT  = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the core port, debug/loader port and memory port of dmem_arbiter.
// slave = arbiter side, master = requesters plus memory.
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH_P      = 32,
    parameter int DATA_ADDR_WIDTH_P = 32,
    parameter int MEM_ADDR_WIDTH_P  = 8
);
    logic                         i_core_req;
    logic                         i_core_we;
    logic [DATA_ADDR_WIDTH_P-1:0] i_core_addr;
    logic [DATA_WIDTH_P-1:0]      i_core_wdata;
    logic                         o_core_gnt;
    logic                         o_core_rvalid;
    logic [DATA_WIDTH_P-1:0]      o_core_rdata;
    logic                         o_core_stall;

    logic                         i_dbg_req;
    logic                         i_dbg_we;
    logic [DATA_ADDR_WIDTH_P-1:0] i_dbg_addr;
    logic [DATA_WIDTH_P-1:0]      i_dbg_wdata;
    logic                         o_dbg_gnt;
    logic                         o_dbg_rvalid;
    logic [DATA_WIDTH_P-1:0]      o_dbg_rdata;

    logic                         o_mem_en;
    logic                         o_mem_we;
    logic [MEM_ADDR_WIDTH_P-1:0]  o_mem_addr;
    logic [DATA_WIDTH_P-1:0]      o_mem_wdata;
    logic [DATA_WIDTH_P-1:0]      i_mem_rdata;
    logic                         o_err;

    modport slave (
        input  i_core_req, i_core_we, i_core_addr, i_core_wdata,
        input  i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
        input  i_mem_rdata,
        output o_core_gnt, o_core_rvalid, o_core_rdata, o_core_stall,
        output o_dbg_gnt, o_dbg_rvalid, o_dbg_rdata,
        output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_err
    );

    modport master (
        output i_core_req, i_core_we, i_core_addr, i_core_wdata,
        output i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
        output i_mem_rdata,
        input  o_core_gnt, o_core_rvalid, o_core_rdata, o_core_stall,
        input  o_dbg_gnt, o_dbg_rvalid, o_dbg_rdata,
        input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_err
    );

endinterface

// File: rtl/dmem_arb_pick.sv
// Two-request picker: core wins ties unless prefer_dbg is set by the
// round-robin pointer in the parent.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic core_req,
    input  logic dbg_req,
    input  logic prefer_dbg,
    output logic any_req,
    output logic winner
);

    assign any_req = core_req | dbg_req;
    assign winner  = (dbg_req && (!core_req || prefer_dbg)) ? DBG_PORT : CORE_PORT;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a core port and a debug/loader port onto one single-port data
// memory. Define DMEM_ARB_ROUND_ROBIN_EN for round-robin ties (else core wins).
//
// state  | meaning
// IDLE   | pick a winner among pending requests, latch its fields
// ACCESS | memory strobe and gnt pulse; writes finish here
// RESP   | memory read data forwarded to the winner with rvalid
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH_P      = 32,
    parameter int DATA_ADDR_WIDTH_P = 32,
    parameter int MEM_ADDR_WIDTH_P  = 8
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    localparam int IDX_HI = MEM_ADDR_WIDTH_P + 1;

    state_t                      state;
    logic                        win_q;
    logic                        we_q;
    logic                        oor_q;
    logic [MEM_ADDR_WIDTH_P-1:0] idx_q;
    logic [DATA_WIDTH_P-1:0]     wdata_q;
    logic                        gnt_core_q, gnt_dbg_q;
    logic                        rv_core_q, rv_dbg_q;
    logic                        mem_en_q, mem_we_q, err_q;

    logic                        any_req, winner, prefer_dbg;
    logic                        sel_we, sel_oor;
    logic [MEM_ADDR_WIDTH_P-1:0] sel_idx;
    logic [DATA_WIDTH_P-1:0]     sel_wdata;

    dmem_arb_pick u_pick (
        .core_req   (bus.i_core_req),
        .dbg_req    (bus.i_dbg_req),
        .prefer_dbg (prefer_dbg),
        .any_req    (any_req),
        .winner     (winner)
    );

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic rr_last;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_last <= DBG_PORT;
        end else if (state == IDLE && any_req) begin
            rr_last <= winner;
        end
    end

    assign prefer_dbg = (rr_last == CORE_PORT);
`else
    assign prefer_dbg = 1'b0;
`endif

    assign sel_we    = (winner == DBG_PORT) ? bus.i_dbg_we : bus.i_core_we;
    assign sel_idx   = (winner == DBG_PORT) ? bus.i_dbg_addr[IDX_HI:2] : bus.i_core_addr[IDX_HI:2];
    assign sel_wdata = (winner == DBG_PORT) ? bus.i_dbg_wdata : bus.i_core_wdata;
    assign sel_oor   = (winner == DBG_PORT) ? |bus.i_dbg_addr[DATA_ADDR_WIDTH_P-1:IDX_HI+1]
                                            : |bus.i_core_addr[DATA_ADDR_WIDTH_P-1:IDX_HI+1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            win_q      <= CORE_PORT;
            we_q       <= 1'b0;
            oor_q      <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            gnt_core_q <= 1'b0;
            gnt_dbg_q  <= 1'b0;
            rv_core_q  <= 1'b0;
            rv_dbg_q   <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            gnt_core_q <= 1'b0;
            gnt_dbg_q  <= 1'b0;
            rv_core_q  <= 1'b0;
            rv_dbg_q   <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            err_q      <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        win_q      <= winner;
                        we_q       <= sel_we;
                        oor_q      <= sel_oor;
                        idx_q      <= sel_idx;
                        wdata_q    <= sel_wdata;
                        mem_en_q   <= ~sel_oor;
                        mem_we_q   <= sel_we;
                        err_q      <= sel_oor;
                        gnt_core_q <= (winner == CORE_PORT);
                        gnt_dbg_q  <= (winner == DBG_PORT);
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (we_q) begin
                        state <= IDLE;
                    end else begin
                        rv_core_q <= (win_q == CORE_PORT);
                        rv_dbg_q  <= (win_q == DBG_PORT);
                        state     <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are masked by reset so a reset landing mid-transaction issues
    // no memory write, gnt or rvalid in that same cycle.
    assign bus.o_core_gnt    = gnt_core_q & reset;
    assign bus.o_dbg_gnt     = gnt_dbg_q & reset;
    assign bus.o_core_rvalid = rv_core_q & reset;
    assign bus.o_dbg_rvalid  = rv_dbg_q & reset;
    assign bus.o_mem_en      = mem_en_q & reset;
    assign bus.o_mem_we      = mem_we_q & reset;
    assign bus.o_mem_addr    = idx_q & {MEM_ADDR_WIDTH_P{reset}};
    assign bus.o_mem_wdata   = wdata_q & {DATA_WIDTH_P{reset}};
    assign bus.o_err         = err_q & reset;

    // Memory data only arrives in RESP, so it is forwarded straight through
    // to keep reads at three cycles; out-of-range reads return zero.
    assign bus.o_core_rdata = (bus.o_core_rvalid && !oor_q) ? bus.i_mem_rdata : '0;
    assign bus.o_dbg_rdata  = (bus.o_dbg_rvalid && !oor_q) ? bus.i_mem_rdata : '0;

    assign bus.o_core_stall = bus.i_core_req &
                              ~((bus.o_core_gnt & bus.i_core_we) | (bus.o_core_rvalid & ~bus.i_core_we));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural
// single-port synchronous memory behind the arbiter.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    dmem_arbiter_if bus ();

    dmem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    logic        mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem_init <= 1'b1;
        end else if (bus.o_mem_en) begin
            if (bus.o_mem_we) mem[bus.o_mem_addr] <= bus.o_mem_wdata;
            else              bus.i_mem_rdata <= mem[bus.o_mem_addr];
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drop_reqs();
        bus.i_core_req = 1'b0;
        bus.i_dbg_req  = 1'b0;
    endtask

    task automatic xact(input bit dbg, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output int stalls, output logic [31:0] rdata,
                        output bit saw_err, output bit saw_en, output logic [7:0] en_addr,
                        output bit en_we);
        bit done;
        done = 0; lat = -1; stalls = 0; rdata = '0;
        saw_err = 0; saw_en = 0; en_addr = '0; en_we = 0;
        @(negedge clk);
        if (dbg) begin
            bus.i_dbg_req = 1'b1; bus.i_dbg_we = we; bus.i_dbg_addr = addr; bus.i_dbg_wdata = wdata;
        end else begin
            bus.i_core_req = 1'b1; bus.i_core_we = we; bus.i_core_addr = addr; bus.i_core_wdata = wdata;
        end
        for (int c = 0; c < 12 && !done; c++) begin
            #1;
            if (bus.o_core_stall) stalls++;
            if (bus.o_err) saw_err = 1;
            if (bus.o_mem_en) begin
                saw_en = 1; en_addr = bus.o_mem_addr; en_we = bus.o_mem_we;
            end
            if (we ? (dbg ? bus.o_dbg_gnt : bus.o_core_gnt) : (dbg ? bus.o_dbg_rvalid : bus.o_core_rvalid)) begin
                done  = 1;
                lat   = c;
                rdata = dbg ? bus.o_dbg_rdata : bus.o_core_rdata;
                drop_reqs();
            end
            @(negedge clk);
        end
        drop_reqs();
    endtask

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    localparam int CORE_READS = 1;
    localparam int DBG_CYC    = 5;
`else
    localparam int CORE_READS = 4;
    localparam int DBG_CYC    = 14;
`endif

    initial begin
        int          lat, stalls, core_first, dbg_cyc, core_cnt, overlap;
        logic [31:0] rdata, dbg_data, r;
        bit          saw_err, saw_en, en_we;
        logic [7:0]  en_addr;

        bus.i_core_req = 0; bus.i_core_we = 0; bus.i_core_addr = '0; bus.i_core_wdata = '0;
        bus.i_dbg_req  = 0; bus.i_dbg_we  = 0; bus.i_dbg_addr  = '0; bus.i_dbg_wdata  = '0;

        // reset state
        repeat (3) @(negedge clk);
        bus.i_core_req = 1'b1;
        #1;
        check_val("rst_gnt",    {bus.o_core_gnt, bus.o_dbg_gnt}, 2'b00);
        check_val("rst_rvalid", {bus.o_core_rvalid, bus.o_dbg_rvalid}, 2'b00);
        check_val("rst_mem",    {bus.o_mem_en, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata}, '0);
        check_val("rst_err",    bus.o_err, 1'b0);
        check_val("rst_rdata",  {bus.o_core_rdata, bus.o_dbg_rdata}, '0);
        check_val("rst_state",  dut.state, IDLE);
        bus.i_core_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // core write 7 -> 80
        xact(0, 1, 32'd80, 32'd7, lat, stalls, rdata, saw_err, saw_en, en_addr, en_we);
        check_val("wr_lat",    lat, 1);
        check_val("wr_stall",  stalls, 1);
        check_val("wr_addr",   en_addr, 8'd20);
        check_val("wr_we",     en_we, 1'b1);
        check_val("wr_mem20",  mem[20], 32'd7);

        // core read 80
        xact(0, 0, 32'd80, 32'd0, lat, stalls, rdata, saw_err, saw_en, en_addr, en_we);
        check_val("rd_lat",    lat, 2);
        check_val("rd_stall",  stalls, 2);
        check_val("rd_data",   rdata, 32'd7);

        // reset during ACCESS of a core write 5 -> 84
        @(negedge clk);
        bus.i_core_req = 1'b1; bus.i_core_we = 1'b1; bus.i_core_addr = 32'd84; bus.i_core_wdata = 32'd5;
        @(negedge clk);
        check_val("abort_in_access", dut.state, ACCESS);
        reset = 1'b0;
        #1;
        check_val("abort_gnt",   bus.o_core_gnt, 1'b0);
        check_val("abort_mem_en", bus.o_mem_en, 1'b0);
        @(negedge clk);
        check_val("abort_state", dut.state, IDLE);
        drop_reqs();
        reset = 1'b1;
        @(negedge clk);
        check_val("abort_mem21", mem[21], 32'd0);

        // dbg out-of-range read
        xact(1, 0, 32'h400, 32'd0, lat, stalls, rdata, saw_err, saw_en, en_addr, en_we);
        check_val("oor_lat",   lat, 2);
        check_val("oor_err",   saw_err, 1'b1);
        check_val("oor_en",    saw_en, 1'b0);
        check_val("oor_rdata", rdata, 32'd0);

        // simultaneous core and dbg reads
        @(negedge clk);
        bus.i_core_req = 1'b1; bus.i_core_we = 1'b0; bus.i_core_addr = 32'd80;
        bus.i_dbg_req  = 1'b1; bus.i_dbg_we  = 1'b0; bus.i_dbg_addr  = 32'd80;
        core_first = -1; dbg_cyc = -1; core_cnt = 0; overlap = 0; dbg_data = '0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if ((bus.o_core_gnt && bus.o_dbg_gnt) || (bus.o_core_rvalid && bus.o_dbg_rvalid)) overlap++;
            if (bus.o_core_rvalid) begin
                core_cnt++;
                if (core_first < 0) core_first = c;
                if (core_cnt == CORE_READS) bus.i_core_req = 1'b0;
            end
            if (bus.o_dbg_rvalid) begin
                if (dbg_cyc < 0) dbg_cyc = c;
                dbg_data = bus.o_dbg_rdata;
                bus.i_dbg_req = 1'b0;
            end
            @(negedge clk);
        end
        drop_reqs();
        check_val("both_core_first", core_first, 2);
        check_val("both_core_cnt",   core_cnt, CORE_READS);
        check_val("both_dbg_cyc",    dbg_cyc, DBG_CYC);
        check_val("both_dbg_data",   dbg_data, 32'd7);
        check_val("both_overlap",    overlap, 0);

        // loader fills words 0..3, then core sw/lw/sw
        for (int i = 0; i < 4; i++) begin
            xact(1, 1, 32'(i * 4), 32'h100 + 32'(i), lat, stalls, rdata, saw_err, saw_en, en_addr, en_we);
        end
        check_val("ld_mem0", mem[0], 32'h100);
        check_val("ld_mem3", mem[3], 32'h103);
        xact(0, 1, 32'd80, 32'd7, lat, stalls, rdata, saw_err, saw_en, en_addr, en_we);
        xact(0, 0, 32'd80, 32'd0, lat, stalls, r, saw_err, saw_en, en_addr, en_we);
        check_val("seq_lw", r, 32'd7);
        xact(0, 1, 32'd84, r, lat, stalls, rdata, saw_err, saw_en, en_addr, en_we);
        @(negedge clk);
        check_val("seq_mem21", mem[21], 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
